// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and index-width helper for the argmax classifier.
package nn_pkg;

    localparam int unsigned DEF_NUM_CLASSES = 10;
    localparam int unsigned DEF_NUM_PIXELS  = 784;
    localparam int unsigned DEF_PIX_WIDTH   = 1;
    localparam int unsigned DEF_W_WIDTH     = 16;
    localparam int unsigned DEF_ACC_WIDTH   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StArgmax,
        StDone
    } state_e;

    // Width of a class index; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/mac_argmax_classifier_if.sv
// Pixel stream / result bus between the streamer+controller (master) and the classifier (slave).
interface mac_argmax_classifier_if
    import nn_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int unsigned PIX_WIDTH   = DEF_PIX_WIDTH,
    parameter int unsigned W_WIDTH     = DEF_W_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH
);

    logic                                 start;
    logic                                 pix_valid;
    logic                                 pix_ready;
    logic [PIX_WIDTH-1:0]                 pixel;
    logic [NUM_CLASSES*W_WIDTH-1:0]       weights;
    logic                                 busy;
    logic                                 result_valid;
    logic [idx_width(NUM_CLASSES)-1:0]    classification;
    logic [NUM_CLASSES*ACC_WIDTH-1:0]     scores;

    modport master (
        output start, pix_valid, pixel, weights,
        input  pix_ready, busy, result_valid, classification, scores
    );

    modport slave (
        input  start, pix_valid, pixel, weights,
        output pix_ready, busy, result_valid, classification, scores
    );

endinterface

// File: rtl/mac_lane.sv
// Single-class multiply-accumulate lane: acc += sext(weight * zext(pixel)).
// Build option SATURATE_EN: clamp to the signed accumulator range and raise a sticky sat flag.
module mac_lane #(
    parameter int unsigned PIX_WIDTH = 1,
    parameter int unsigned W_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        enable,
    input  logic [PIX_WIDTH-1:0]        pixel,
    input  logic signed [W_WIDTH-1:0]   weight,
`ifdef SATURATE_EN
    output logic                        sat,
`endif
    output logic signed [ACC_WIDTH-1:0] acc
);

    localparam int unsigned ProdW = W_WIDTH + PIX_WIDTH + 1;

    logic signed [ProdW-1:0]     weight_ext, pixel_ext, prod;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_next;

    assign weight_ext = ProdW'(weight);
    assign pixel_ext  = ProdW'({1'b0, pixel});
    assign prod       = weight_ext * pixel_ext;
    assign acc        = acc_q;

`ifdef SATURATE_EN
    // Sum is formed one bit wider than either operand so overflow is visible before clamping.
    localparam int unsigned SumW = ((ACC_WIDTH > ProdW) ? ACC_WIDTH : ProdW) + 1;
    localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] AccMin = ~AccMax;

    logic signed [SumW-1:0] sum;
    logic                   ovf;
    logic                   sat_q;

    // Wide add then clamp on overflow.
    always_comb begin
        sum = SumW'(acc_q) + SumW'(prod);
        ovf = (sum > SumW'(AccMax)) || (sum < SumW'(AccMin));
        if (ovf) begin
            acc_next = sum[SumW-1] ? AccMin : AccMax;
        end else begin
            acc_next = ACC_WIDTH'(sum);
        end
    end

    // Sticky saturation flag, cleared per image.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sat_q <= 1'b0;
        end else if (enable && ovf) begin
            sat_q <= 1'b1;
        end
    end

    assign sat = sat_q;
`else
    // Two's-complement wrap.
    always_comb begin
        acc_next = acc_q + ACC_WIDTH'(prod);
    end
`endif

    // Accumulator register: clear has priority over accumulate.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/mac_argmax_classifier.sv
// Streaming linear-layer classifier: per-class MAC over NUM_PIXELS beats, then a
// one-compare-per-cycle argmax. Build option SATURATE_EN adds saturation and sat_flag.
module mac_argmax_classifier
    import nn_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int unsigned NUM_PIXELS  = DEF_NUM_PIXELS,
    parameter int unsigned PIX_WIDTH   = DEF_PIX_WIDTH,
    parameter int unsigned W_WIDTH     = DEF_W_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef SATURATE_EN
    output logic                  sat_flag,
`endif
    mac_argmax_classifier_if.slave bus
);

    localparam int unsigned IdxW = idx_width(NUM_CLASSES);
    localparam int unsigned CntW = $clog2(NUM_PIXELS + 1);

    state_e                           state_q, state_d;
    logic [CntW-1:0]                  cnt_q, cnt_d;
    logic [IdxW-1:0]                  arg_idx_q, arg_idx_d;
    logic [IdxW-1:0]                  best_idx_q, best_idx_d;
    logic [IdxW-1:0]                  class_q, class_d;
    logic signed [ACC_WIDTH-1:0]      best_val_q, best_val_d;
    logic [NUM_CLASSES*ACC_WIDTH-1:0] scores_q, scores_flat;
    logic                             rv_q, rv_d;
    logic                             load_result;
    logic                             beat, lane_clear, take;
    logic signed [ACC_WIDTH-1:0]      acc [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]      cand;

    assign bus.pix_ready      = (state_q == StAccum);
    assign bus.busy           = (state_q != StIdle);
    assign bus.result_valid   = rv_q;
    assign bus.classification = class_q;
    assign bus.scores         = scores_q;

    assign beat       = bus.pix_valid && (state_q == StAccum);
    assign lane_clear = (state_q == StIdle) && bus.start;

`ifdef SATURATE_EN
    logic [NUM_CLASSES-1:0] lane_sat;
    assign sat_flag = |lane_sat;
`endif

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        mac_lane #(
            .PIX_WIDTH (PIX_WIDTH),
            .W_WIDTH   (W_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clear  (lane_clear),
            .enable (beat),
            .pixel  (bus.pixel),
            .weight (bus.weights[k*W_WIDTH +: W_WIDTH]),
`ifdef SATURATE_EN
            .sat    (lane_sat[k]),
`endif
            .acc    (acc[k])
        );
        assign scores_flat[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
    end

    // Argmax step: index 0 seeds best; later indices replace only when strictly greater.
    assign cand = acc[arg_idx_q];
    assign take = (arg_idx_q == '0) || (cand > best_val_q);

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arg_idx_d   = arg_idx_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        class_d     = class_q;
        rv_d        = 1'b0;
        load_result = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                end
            end
            StAccum: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(NUM_PIXELS - 1)) begin
                        state_d   = StArgmax;
                        arg_idx_d = '0;
                    end
                end
            end
            StArgmax: begin
                if (take) begin
                    best_val_d = cand;
                    best_idx_d = arg_idx_q;
                end
                arg_idx_d = arg_idx_q + 1'b1;
                if (arg_idx_q == IdxW'(NUM_CLASSES - 1)) begin
                    // Last compare folds straight into the registered result.
                    state_d     = StDone;
                    arg_idx_d   = '0;
                    class_d     = take ? arg_idx_q : best_idx_q;
                    rv_d        = 1'b1;
                    load_result = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            arg_idx_q  <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            class_q    <= '0;
            rv_q       <= 1'b0;
            scores_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arg_idx_q  <= arg_idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            class_q    <= class_d;
            rv_q       <= rv_d;
            if (load_result) begin
                scores_q <= scores_flat;
            end
        end
    end

endmodule

// File: tb/tb_mac_argmax_classifier.sv
// Self-checking bench for mac_argmax_classifier: directed vector table, random-gap image
// against a reference model, mid-image reset, and a narrow-accumulator overflow instance.
module tb_mac_argmax_classifier;

    localparam int NC = 10;
    localparam int NP = 784;
    localparam int PW = 1;
    localparam int WW = 16;
    localparam int AW = 32;

    typedef struct {
        int mode;
        int exp_class;
        int exp_s0;
        int exp_s3;
        int exp_s7;
        int exp_s9;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_argmax_classifier_if #(.NUM_CLASSES(NC), .PIX_WIDTH(PW), .W_WIDTH(WW), .ACC_WIDTH(AW))
        bus ();
    mac_argmax_classifier_if #(.NUM_CLASSES(2), .PIX_WIDTH(1), .W_WIDTH(16), .ACC_WIDTH(16))
        bus2 ();

`ifdef SATURATE_EN
    logic sat_flag, sat_flag2;
`endif

    mac_argmax_classifier #(
        .NUM_CLASSES (NC),
        .NUM_PIXELS  (NP),
        .PIX_WIDTH   (PW),
        .W_WIDTH     (WW),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef SATURATE_EN
        .sat_flag (sat_flag),
`endif
        .bus      (bus)
    );

    mac_argmax_classifier #(
        .NUM_CLASSES (2),
        .NUM_PIXELS  (NP),
        .PIX_WIDTH   (1),
        .W_WIDTH     (16),
        .ACC_WIDTH   (16)
    ) dut_narrow (
        .clk      (clk),
        .reset    (reset),
`ifdef SATURATE_EN
        .sat_flag (sat_flag2),
`endif
        .bus      (bus2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int rv_cyc = 0;
    int rv_count = 0;
    int model [NC];
    vec_t vecs [4];

    // Cycle bookkeeping for latency and pulse counting.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.pix_valid && bus.pix_ready) last_acc_cyc <= cyc;
        if (bus.result_valid) begin
            rv_cyc   <= cyc;
            rv_count <= rv_count + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int w_of(input int mode, input int k);
        case (mode)
            0: return k;
            1: return 5;
            2: return (k == 3) ? -1 : -2;
            3: return (k == 7) ? 3 : 1;
            default: return 0;
        endcase
    endfunction

    function automatic int px_of(input int mode, input int b);
        if (mode == 3) return ((b % 2) == 0) ? 1 : 0;
        return 1;
    endfunction

    function automatic int score(input int k);
        return int'($signed(bus.scores[k*AW +: AW]));
    endfunction

    function automatic int model_class();
        int best = model[0];
        int idx = 0;
        for (int i = 1; i < NC; i++) begin
            if (model[i] > best) begin
                best = model[i];
                idx = i;
            end
        end
        return idx;
    endfunction

    // Stream one image (directed mode or random pixels/weights/gaps) and wait for its result.
    task automatic run_image(input int mode, input bit rnd, output bit ok);
        int b;
        int guard;
        int v, px, rdy;
        int wk [NC];
        bit poked;
        b = 0;
        guard = 0;
        poked = 1'b0;
        for (int k = 0; k < NC; k++) model[k] = 0;
        @(negedge clk);
        bus.start = 1'b1;
        while (b < NP && guard < 20000) begin
            @(negedge clk);
            guard++;
            bus.start = 1'b0;
            if (rnd && b == 100 && !poked) begin
                bus.start = 1'b1;
                poked = 1'b1;
            end
            v  = rnd ? int'($urandom_range(1)) : 1;
            px = rnd ? int'($urandom_range(1)) : px_of(mode, b);
            for (int k = 0; k < NC; k++) begin
                wk[k] = rnd ? int'($urandom_range(65535)) - 32768 : w_of(mode, k);
                bus.weights[k*WW +: WW] = WW'(wk[k]);
            end
            bus.pix_valid = v[0];
            bus.pixel = PW'(px);
            rdy = int'(bus.pix_ready);
            chk("pix_ready_in_accum", rdy, 1);
            @(posedge clk);
            if (v != 0 && rdy != 0) begin
                for (int k = 0; k < NC; k++) model[k] += wk[k] * px;
                b++;
            end
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.result_valid) begin
                ok = 1'b1;
                break;
            end
            chk("pix_ready_low_after_accum", bus.pix_ready, 0);
            @(negedge clk);
        end
        chk("result_timeout", ok, 1);
    endtask

    initial begin
        bit ok;
        int rc;
        bus.start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pixel = '0;
        bus.weights = '0;
        bus2.start = 1'b0;
        bus2.pix_valid = 1'b0;
        bus2.pixel = '0;
        bus2.weights = '0;

        vecs[0] = '{mode: 0, exp_class: 9, exp_s0: 0, exp_s3: 2352, exp_s7: 5488, exp_s9: 7056};
        vecs[1] = '{mode: 1, exp_class: 0, exp_s0: 3920, exp_s3: 3920, exp_s7: 3920,
                    exp_s9: 3920};
        vecs[2] = '{mode: 2, exp_class: 3, exp_s0: -1568, exp_s3: -784, exp_s7: -1568,
                    exp_s9: -1568};
        vecs[3] = '{mode: 3, exp_class: 7, exp_s0: 392, exp_s3: 392, exp_s7: 1176, exp_s9: 392};

        // Reset with start held high: reset must win.
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_with_reset_busy", bus.busy, 0);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_pix_ready", bus.pix_ready, 0);
        chk("reset_result_valid", bus.result_valid, 0);
        chk("reset_class", bus.classification, 0);
        chk("reset_scores_zero", longint'(|bus.scores), 0);
`ifdef SATURATE_EN
        chk("reset_sat_flag", sat_flag2, 0);
`endif

        // Directed vector table.
        foreach (vecs[i]) begin
            rc = rv_count;
            run_image(vecs[i].mode, 1'b0, ok);
            chk("vec_class", bus.classification, vecs[i].exp_class);
            chk("vec_score0", score(0), vecs[i].exp_s0);
            chk("vec_score3", score(3), vecs[i].exp_s3);
            chk("vec_score7", score(7), vecs[i].exp_s7);
            chk("vec_score9", score(9), vecs[i].exp_s9);
            @(negedge clk);
            chk("vec_latency", rv_cyc - last_acc_cyc, NC + 1);
            chk("vec_rv_one_pulse", bus.result_valid, 0);
            chk("vec_rv_count", rv_count, rc + 1);
            chk("vec_class_hold", bus.classification, vecs[i].exp_class);
        end

        // Random pixels, weights and valid gaps; a start pulse inside ACCUM must be ignored.
        run_image(4, 1'b1, ok);
        chk("rand_class", bus.classification, model_class());
        for (int k = 0; k < NC; k++) chk("rand_score", score(k), model[k]);

        // Abandon an image at beat 400 with reset; no result may appear.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pixel = 1'b1;
        for (int k = 0; k < NC; k++) bus.weights[k*WW +: WW] = WW'(k);
        repeat (400) @(negedge clk);
        reset = 1'b1;
        bus.pix_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rc = rv_count;
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_pix_ready", bus.pix_ready, 0);
        repeat (30) @(negedge clk);
        chk("midreset_no_result", rv_count, rc);
        run_image(0, 1'b0, ok);
        chk("after_reset_class", bus.classification, 9);
        chk("after_reset_score9", score(9), 7056);
        chk("after_reset_score1", score(1), 784);

        // Narrow accumulator: 784 x 32767 overflows 16 bits.
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        bus2.pix_valid = 1'b1;
        bus2.pixel = 1'b1;
        bus2.weights = 32'h0000_7fff;
        repeat (NP) @(negedge clk);
        bus2.pix_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus2.result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("narrow_result_timeout", ok, 1);
        chk("narrow_score1", $signed(bus2.scores[31:16]), 0);
`ifdef SATURATE_EN
        chk("narrow_score0_sat", $signed(bus2.scores[15:0]), 32767);
        chk("narrow_class_sat", bus2.classification, 0);
        chk("narrow_sat_flag", sat_flag2, 1);
`else
        chk("narrow_score0_wrap", $signed(bus2.scores[15:0]), -784);
        chk("narrow_class_wrap", bus2.classification, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
